// File: rtl/icache_refill_ctrl_if.sv
// Signal bundle between the I-cache refill controller, the cache lookup stage and line-fill memory.
// The master view belongs to the controller; the slave view is the cache/memory side.
interface icache_refill_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) ();
  logic              miss_valid;
  logic [ADDR_W-1:0] miss_addr;
  logic              miss_ready;
  logic              refill_valid;
  logic [ADDR_W-1:0] refill_addr;
  logic [LINE_W-1:0] refill_data;
  logic              refill_err;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_data_in;
  logic              mem_ready;

  modport master (
    input  miss_valid, miss_addr, mem_data_in, mem_ready,
    output miss_ready, refill_valid, refill_addr, refill_data, refill_err,
    output mem_req, mem_addr
  );

  modport slave (
    output miss_valid, miss_addr, mem_data_in, mem_ready,
    input  miss_ready, refill_valid, refill_addr, refill_data, refill_err,
    input  mem_req, mem_addr
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// I-cache line refill initiator: takes one miss at a time, issues a line-aligned memory request,
// returns the captured line or an error pulse on timeout, then enforces an idle gap.
module icache_refill_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128,
  parameter int TIMEOUT_CYC = 64,
  parameter int REQ_GAP     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  icache_refill_ctrl_if.master bus_io
);

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(REQ_GAP + 1);

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(REQ_GAP);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    DONE = 3'd2,
    ERR  = 3'd3,
    GAP  = 3'd4
  } state_e;

  state_e            state_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [GAP_W-1:0]  gap_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [ADDR_W-1:0] req_addr_d;
  logic              miss_ready_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              refill_valid_q;
  logic              refill_err_q;
  logic [ADDR_W-1:0] refill_addr_q;
  logic [LINE_W-1:0] refill_data_q;

  assign req_addr_d = bus_io.miss_addr & ~OFF_MASK;

  // Every output is a register so mem_req/mem_addr cannot glitch and drop together on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      tmr_q          <= '0;
      gap_q          <= GAP_LAST;
      req_addr_q     <= '0;
      miss_ready_q   <= 1'b1;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      refill_valid_q <= 1'b0;
      refill_err_q   <= 1'b0;
      refill_addr_q  <= '0;
      refill_data_q  <= '0;
    end else begin
      refill_valid_q <= 1'b0;
      refill_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus_io.miss_valid) begin
            req_addr_q   <= req_addr_d;
            mem_addr_q   <= req_addr_d;
            mem_req_q    <= 1'b1;
            miss_ready_q <= 1'b0;
            tmr_q        <= TMR_W'(1);
            state_q      <= REQ;
          end
        end
        REQ: begin
          // A response on the final timer cycle still counts as a successful fill.
          if (bus_io.mem_ready) begin
            refill_data_q  <= bus_io.mem_data_in;
            refill_addr_q  <= req_addr_q;
            refill_valid_q <= 1'b1;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            state_q        <= DONE;
          end else if (tmr_q == TMR_LAST) begin
            refill_err_q <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            state_q      <= ERR;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        DONE, ERR: begin
          gap_q   <= GAP_W'(1);
          state_q <= GAP;
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            miss_ready_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: begin
          miss_ready_q <= 1'b1;
          mem_req_q    <= 1'b0;
          mem_addr_q   <= '0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign bus_io.miss_ready   = miss_ready_q;
  assign bus_io.mem_req      = mem_req_q;
  assign bus_io.mem_addr     = mem_addr_q;
  assign bus_io.refill_valid = refill_valid_q;
  assign bus_io.refill_err   = refill_err_q;
  assign bus_io.refill_addr  = refill_addr_q;
  assign bus_io.refill_data  = refill_data_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: a table of single-miss transactions plus
// hand-written sequences for spurious responses, back-to-back misses and reset mid-request.
module tb_icache_refill_ctrl;

  localparam int ADDR_W      = 32;
  localparam int LINE_W      = 128;
  localparam int TIMEOUT_CYC = 64;
  localparam int REQ_GAP     = 2;
  localparam int NVEC        = 6;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  icache_refill_ctrl_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  icache_refill_ctrl #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT_CYC(TIMEOUT_CYC), .REQ_GAP(REQ_GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_io(bus)
  );

  // readyAt: REQ cycle (1-based) on which mem_ready is driven; 0 means memory never answers.
  typedef struct {
    logic [ADDR_W-1:0] missAddr;
    int                readyAt;
    logic [LINE_W-1:0] data;
    logic [ADDR_W-1:0] expAddr;
    logic              expValid;
    logic              expErr;
    int                expReqCycles;
  } vec_t;

  vec_t vecs[NVEC];

  int compared   = 0;
  int mismatched = 0;

  logic [LINE_W-1:0] modelData;
  logic [LINE_W-1:0] expData;

  int                reqCycles;
  int                gapCycles;
  logic              addrStable;
  logic              gotValid;
  logic              gotErr;
  logic [LINE_W-1:0] gotData;
  logic [ADDR_W-1:0] gotAddr;
  logic              pulseCleared;
  logic              timedOut;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Runs one complete miss: waits for miss_ready, issues the miss, answers per the vector,
  // captures the pulse cycle and counts the idle cycles until the controller is ready again.
  task automatic applyStimulus(input vec_t v,
                               output int rc, output logic stable,
                               output logic vld, output logic err,
                               output logic [LINE_W-1:0] dat, output logic [ADDR_W-1:0] adr,
                               output logic cleared, output int gc, output logic tmo);
    int guard;
    rc = 0; gc = 0; stable = 1'b1; vld = 1'b0; err = 1'b0;
    dat = '0; adr = '0; cleared = 1'b0; tmo = 1'b0;
    guard = 0;
    while (bus.miss_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      tmo = 1'b1;
      return;
    end
    bus.miss_valid = 1'b1;
    bus.miss_addr  = v.missAddr;
    @(negedge clk);
    bus.miss_valid = 1'b0;
    bus.miss_addr  = '0;
    guard = 0;
    while (bus.mem_req === 1'b1 && guard < TIMEOUT_CYC + 10) begin
      rc++;
      if (bus.mem_addr !== v.expAddr) stable = 1'b0;
      if (rc == v.readyAt) begin
        bus.mem_ready   = 1'b1;
        bus.mem_data_in = v.data;
      end else begin
        bus.mem_ready   = 1'b0;
        bus.mem_data_in = ~v.data;
      end
      @(negedge clk);
      guard++;
    end
    if (guard >= TIMEOUT_CYC + 10) tmo = 1'b1;
    bus.mem_ready   = 1'b0;
    bus.mem_data_in = ~v.data;
    vld = bus.refill_valid;
    err = bus.refill_err;
    dat = bus.refill_data;
    adr = bus.refill_addr;
    @(negedge clk);
    cleared = (bus.refill_valid === 1'b0) && (bus.refill_err === 1'b0);
    guard = 0;
    while (bus.miss_ready !== 1'b1 && guard < 20) begin
      if (bus.mem_req !== 1'b0) stable = 1'b0;
      gc++;
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) tmo = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [LINE_W-1:0] d1;
    logic [LINE_W-1:0] lastResp;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    int                reqSeen;
    int                validCount;
    int                lowRun;
    int                lowBetween;
    int                bothHigh;
    logic              prevReq;

    rst             = 1'b1;
    bus.miss_valid  = 1'b0;
    bus.miss_addr   = '0;
    bus.mem_ready   = 1'b0;
    bus.mem_data_in = '0;
    modelData       = '0;

    vecs[0] = '{32'h1234_567B, 3,  128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF,
                32'h1234_5670, 1'b1, 1'b0, 3};
    vecs[1] = '{32'h0000_0000, 1,  128'hCAFE_0001_CAFE_0002_CAFE_0003_CAFE_0004,
                32'h0000_0000, 1'b1, 1'b0, 1};
    vecs[2] = '{32'hFFFF_FFFF, 5,  128'h5A5A_5A5A_A5A5_A5A5_0F0F_0F0F_F0F0_F0F0,
                32'hFFFF_FFF0, 1'b1, 1'b0, 5};
    vecs[3] = '{32'h8000_000F, 0,  128'h1111_2222_3333_4444_5555_6666_7777_8888,
                32'h8000_0000, 1'b0, 1'b1, TIMEOUT_CYC};
    vecs[4] = '{32'hABCD_EF18, TIMEOUT_CYC, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000,
                32'hABCD_EF10, 1'b1, 1'b0, TIMEOUT_CYC};
    vecs[5] = '{32'h0000_0010, 2,  128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                32'h0000_0010, 1'b1, 1'b0, 2};

    // Reset values while reset is held from time zero.
    #3;
    checkOutput("reset miss_ready", bus.miss_ready, 1);
    checkOutput("reset mem_req", bus.mem_req, 0);
    checkOutput("reset mem_addr", bus.mem_addr, 0);
    checkOutput("reset refill_valid", bus.refill_valid, 0);
    checkOutput("reset refill_err", bus.refill_err, 0);
    checkOutput("reset refill_data", bus.refill_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table of single transactions; a timeout must leave refill_data at its previous value.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], reqCycles, addrStable, gotValid, gotErr, gotData, gotAddr,
                    pulseCleared, gapCycles, timedOut);
      expData = vecs[i].expValid ? vecs[i].data : modelData;
      modelData = expData;
      checkOutput($sformatf("vec%0d bounded", i), timedOut, 0);
      checkOutput($sformatf("vec%0d mem_req cycles", i), reqCycles, vecs[i].expReqCycles);
      checkOutput($sformatf("vec%0d mem_addr stable", i), addrStable, 1);
      checkOutput($sformatf("vec%0d refill_valid", i), gotValid, vecs[i].expValid);
      checkOutput($sformatf("vec%0d refill_err", i), gotErr, vecs[i].expErr);
      checkOutput($sformatf("vec%0d refill_data", i), gotData, expData);
      if (vecs[i].expValid)
        checkOutput($sformatf("vec%0d refill_addr", i), gotAddr, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d pulse one cycle", i), pulseCleared, 1);
      checkOutput($sformatf("vec%0d gap cycles", i), gapCycles, REQ_GAP);
    end

    // Spurious mem_ready in DONE, GAP and IDLE must neither capture nor pulse.
    d1 = 128'h7777_0000_1111_2222_3333_4444_5555_6666;
    bus.miss_valid = 1'b1;
    bus.miss_addr  = 32'h0000_0040;
    @(negedge clk);
    bus.miss_valid = 1'b0;
    checkOutput("spur mem_req", bus.mem_req, 1);
    bus.mem_ready   = 1'b1;
    bus.mem_data_in = d1;
    @(negedge clk);
    checkOutput("spur first valid", bus.refill_valid, 1);
    checkOutput("spur first data", bus.refill_data, d1);
    bus.mem_data_in = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("spur c%0d refill_valid", c), bus.refill_valid, 0);
      checkOutput($sformatf("spur c%0d refill_err", c), bus.refill_err, 0);
      checkOutput($sformatf("spur c%0d refill_data", c), bus.refill_data, d1);
      checkOutput($sformatf("spur c%0d mem_req", c), bus.mem_req, 0);
    end
    checkOutput("spur back in idle", bus.miss_ready, 1);
    bus.mem_ready   = 1'b0;
    bus.mem_data_in = '0;

    // Back-to-back: miss_valid held high, memory answers on the first REQ cycle.
    bus.miss_valid = 1'b1;
    bus.miss_addr  = 32'h0000_0000;
    reqSeen = 0; validCount = 0; lowRun = 0; lowBetween = -1; bothHigh = 0;
    prevReq = 1'b0; addr1 = '1; addr2 = '1; lastResp = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.refill_valid === 1'b1) validCount++;
      if (bus.refill_valid === 1'b1 && bus.refill_err === 1'b1) bothHigh++;
      if (bus.mem_req === 1'b1 && prevReq === 1'b0) begin
        if (reqSeen == 0) begin
          addr1         = bus.mem_addr;
          bus.miss_addr = 32'h0000_0010;
        end else begin
          addr2          = bus.mem_addr;
          lowBetween     = lowRun;
          bus.miss_valid = 1'b0;
        end
        reqSeen++;
      end
      if (bus.mem_req === 1'b1) lowRun = 0;
      else if (reqSeen > 0) lowRun++;
      bus.mem_ready   = bus.mem_req;
      bus.mem_data_in = {32'hB2B0_0000, 32'h0, 32'h0, 32'(c)};
      if (bus.mem_req === 1'b1) lastResp = bus.mem_data_in;
      prevReq = bus.mem_req;
    end
    bus.miss_valid = 1'b0;
    bus.mem_ready  = 1'b0;
    checkOutput("b2b requests", reqSeen, 2);
    checkOutput("b2b first addr", addr1, 32'h0000_0000);
    checkOutput("b2b second addr", addr2, 32'h0000_0010);
    checkOutput("b2b refill pulses", validCount, 2);
    checkOutput("b2b low cycles", lowBetween, REQ_GAP + 2);
    checkOutput("b2b valid and err together", bothHigh, 0);
    checkOutput("b2b last data", bus.refill_data, lastResp);
    checkOutput("b2b last addr", bus.refill_addr, 32'h0000_0010);

    // Reset asserted mid-REQ with a response arriving: outputs clear at once, line discarded.
    bus.miss_valid = 1'b1;
    bus.miss_addr  = 32'h2000_0044;
    @(negedge clk);
    bus.miss_valid = 1'b0;
    @(negedge clk);
    checkOutput("rstmid mem_req before", bus.mem_req, 1);
    checkOutput("rstmid mem_addr before", bus.mem_addr, 32'h2000_0040);
    bus.mem_ready   = 1'b1;
    bus.mem_data_in = 128'hBADB_AD00_BADB_AD00_BADB_AD00_BADB_AD00;
    #2 rst = 1'b1;
    #1;
    checkOutput("rstmid mem_req", bus.mem_req, 0);
    checkOutput("rstmid mem_addr", bus.mem_addr, 0);
    checkOutput("rstmid miss_ready", bus.miss_ready, 1);
    checkOutput("rstmid refill_valid", bus.refill_valid, 0);
    checkOutput("rstmid refill_err", bus.refill_err, 0);
    checkOutput("rstmid refill_data", bus.refill_data, 0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("postrst c%0d refill_valid", c), bus.refill_valid, 0);
      checkOutput($sformatf("postrst c%0d mem_req", c), bus.mem_req, 0);
      checkOutput($sformatf("postrst c%0d refill_data", c), bus.refill_data, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
